mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Iterative multiply/divide unit in the E stage of the 5-stage pipeline. Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and services MTHI/MTLO/MFHI/MFLO.
- Raises a stall request toward the hazard logic while an issued instruction cannot proceed. It is the producer of multi-cycle stalls that the hazard unit consumes and merges into StallF/StallD/FlushE.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
startE  in  1  E-stage holds a valid mul/div instruction (already qualified by !FlushE)
opE  in  2  operation, mdu_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3
srcaE  in  WIDTH  rs operand (multiplicand/dividend)
srcbE  in  WIDTH  rt operand (multiplier/divisor)
hiwriteE  in  1  MTHI in E
lowriteE  in  1  MTLO in E
hilosrcE  in  1  MFHI/MFLO in E (needs settled HI/LO)
busy  out  1  operation in flight
stallreq  out  1  to hazard unit: stall F/D, flush E bubble
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
done  out  1  one-cycle pulse when HI/LO updated by mul/div

Behaviour:
- Reset (async, reset_n low): state=IDLE; hi=0; lo=0; busy=0; done=0; internal counters/accumulators=0.
- Reset mid-operation aborts the operation. Operands are discarded and HI/LO are cleared.
- States (mdu_state_t): IDLE, RUN, FIX.
- IDLE:
  - startE=1 latches |srcaE|, |srcbE| (abs only for signed ops), the result sign(s), opE and the original srcaE. Sets count=WIDTH-1 and goes to RUN.
  - The start is accepted in the same cycle; stallreq=0 for that cycle.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring divide, one quotient bit per cycle.
  - count decrements each cycle; at count==0 the next state is FIX. RUN lasts exactly WIDTH cycles.
- FIX (1 cycle):
  - Apply sign correction. Product is negated if signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - On the clock edge leaving FIX: hi/lo are written, done=1 for one cycle, state=IDLE.
- Total latency: start edge to HI/LO valid = WIDTH+1 cycles after acceptance. busy=1 for all RUN and FIX cycles.
- Divide by zero: no trap; iteration still runs. Result is lo=all ones, hi=srcaE (original, unsigned/untouched by sign fix).
- Signed overflow (-2^(W-1) / -1): lo=2^(W-1), hi=0, from the natural unsigned path. Must not hang.
- Multiply results: hi=upper WIDTH bits, lo=lower WIDTH bits of the 2*WIDTH product.
- stallreq = busy & (startE | hiwriteE | lowriteE | hilosrcE), combinational.
  - While stalled, E holds the instruction; it completes the cycle busy drops.
  - In the FIX cycle busy=1, so MFHI stalls one more cycle and reads the new value.
- MTHI/MTLO when !busy: written at the clock edge. MTHI writes hi only, MTLO writes lo only.
- MTHI/MTLO simultaneous with startE cannot occur (single E instruction). If both are asserted, startE wins.
- hi/lo are registered outputs, stable except at the FIX exit edge or an MT edge.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_t enum (MULT, MULTU, DIV, DIVU)
  - mdu_state_t enum (IDLE, RUN, FIX)
  - is_signed(op) and is_div(op) helper functions
  - localparam CNT_W = $clog2(WIDTH)
- One sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator/quotient bit.
  - Instantiated once, used for both mul and div.
- The FSM, counter, sign fix, and HI/LO registers stay in mdu_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high exactly 33 cycles.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV issued, MFHI presented in next cycle -> stallreq=1 until the cycle after the FIX exit edge; MFHI then sees the new hi. A second startE while busy -> stallreq=1 and no restart of the count.
- MTLO 0x1234 while idle -> lo=0x1234 next edge, hi unchanged, stallreq=0. MTHI during RUN -> stalled; after completion the MTHI value overwrites the mul/div hi.
- reset_n pulsed low at RUN cycle 10 -> immediately busy=0, hi=lo=0, no done pulse. A subsequent MULTU 6x7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the iterative multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_signed(input mdu_op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, shift-add multiply or restoring divide
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rsh;
    logic [WIDTH:0] diff;
    logic           qbit;

    // multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        rsh   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff  = rsh - {1'b0, opnd_i};
        qbit  = ~diff[WIDTH];
        acc_o = div_i ? {(qbit ? diff[WIDTH-1:0] : rsh[WIDTH-1:0]), acc_i[WIDTH-2:0], qbit}
                      : {sum, acc_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative MULT/DIV unit owning HI/LO, with stall request to hazard logic
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiwriteE,
    input  logic             lowriteE,
    input  logic             hilosrcE,
    output logic             busy,
    output logic             stallreq,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t         state_q, state_d;
    mdu_op_t            op_q, op_d, op_in;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
    logic [WIDTH-1:0]   opnd_q, opnd_d, srca_q, srca_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_abs, b_abs, quo, rem, res_hi, res_lo;
    logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
    logic               sgn_in;

    assign op_in  = mdu_op_t'(opE);
    assign sgn_in = is_signed(op_in);
    assign a_abs  = (sgn_in && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    assign b_abs  = (sgn_in && srcbE[WIDTH-1]) ? -srcbE : srcbE;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (is_div(op_q)),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // divide by zero bypasses sign correction so hi returns the untouched dividend
    assign prod   = neg_q ? -acc_q : acc_q;
    assign quo    = acc_q[WIDTH-1:0];
    assign rem    = acc_q[2*WIDTH-1:WIDTH];
    assign res_lo = !is_div(op_q) ? prod[WIDTH-1:0] : dz_q ? {WIDTH{1'b1}} : neg_q ? -quo : quo;
    assign res_hi = !is_div(op_q) ? prod[2*WIDTH-1:WIDTH] : dz_q ? srca_q : rneg_q ? -rem : rem;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        srca_d  = srca_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (startE) begin
                    state_d = RUN;
                    op_d    = op_in;
                    cnt_d   = CW'(WIDTH - 1);
                    acc_d   = {{WIDTH{1'b0}}, is_div(op_in) ? a_abs : b_abs};
                    opnd_d  = is_div(op_in) ? b_abs : a_abs;
                    srca_d  = srcaE;
                    neg_d   = sgn_in & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                    rneg_d  = sgn_in & srcaE[WIDTH-1];
                    dz_d    = is_div(op_in) && (srcbE == '0);
                end else begin
                    hi_d = hiwriteE ? srcaE : hi_q;
                    lo_d = lowriteE ? srcaE : lo_q;
                end
            end
            RUN: begin
                acc_d   = step_acc;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? FIX : RUN;
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            srca_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            srca_q  <= srca_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign stallreq = busy & (startE | hiwriteE | lowriteE | hilosrcE);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        startE = 1'b0;
    logic [1:0]  opE = 2'd0;
    logic [31:0] srcaE = '0;
    logic [31:0] srcbE = '0;
    logic        hiwriteE = 1'b0;
    logic        lowriteE = 1'b0;
    logic        hilosrcE = 1'b0;
    logic        busy, stallreq, done;
    logic [31:0] hi, lo;

    localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

    int n_chk = 0;
    int n_fail = 0;
    int bc, dc, ns;

    mdu_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .startE   (startE),
        .opE      (opE),
        .srcaE    (srcaE),
        .srcbE    (srcbE),
        .hiwriteE (hiwriteE),
        .lowriteE (lowriteE),
        .hilosrcE (hilosrcE),
        .busy     (busy),
        .stallreq (stallreq),
        .hi       (hi),
        .lo       (lo),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        #1 chk("stall_on_accept", stallreq, 0);
        @(posedge clk);
        #1 startE = 1'b0;
    endtask

    task automatic run(output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (!busy) break;
            nb++;
        end
        @(negedge clk);
        if (done) nd++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stallreq, 0);
        reset_n = 1'b1;

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(bc, dc);
        chk("multu_busy_cycles", bc, 33);
        chk("multu_done_pulses", dc, 1);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        run(bc, dc);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run(bc, dc);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(OP_DIVU, 32'd100, 32'd0);
        run(bc, dc);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd100);

        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0);
        run(bc, dc);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'hFFFF_FFFB);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run(bc, dc);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);
        chk("divovf_busy_cycles", bc, 33);

        issue(OP_DIV, 32'd50, 32'd7);
        hilosrcE = 1'b1;
        ns = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stallreq) break;
            ns++;
        end
        chk("mfhi_stall_cycles", ns, 33);
        chk("mfhi_hi", hi, 32'd1);
        chk("mfhi_lo", lo, 32'd7);
        hilosrcE = 1'b0;

        issue(OP_MULTU, 32'd3, 32'd5);
        startE = 1'b1;
        opE    = OP_MULTU;
        srcaE  = 32'd2;
        srcbE  = 32'd2;
        ns = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (stallreq) ns++;
        end
        startE = 1'b0;
        chk("restart_stall_cycles", ns, 5);
        run(bc, dc);
        chk("restart_remaining_busy", bc, 28);
        chk("restart_lo", lo, 32'd15);
        chk("restart_hi", hi, 32'd0);

        @(negedge clk);
        lowriteE = 1'b1;
        srcaE    = 32'h1234;
        #1 chk("mtlo_stall", stallreq, 0);
        @(posedge clk);
        #1 lowriteE = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi", hi, 32'd0);

        issue(OP_MULTU, 32'd6, 32'd7);
        hiwriteE = 1'b1;
        srcaE    = 32'hABCD;
        ns = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stallreq) break;
            ns++;
        end
        chk("mthi_stall_cycles", ns, 33);
        chk("mthi_pre_hi", hi, 32'd0);
        @(posedge clk);
        #1 hiwriteE = 1'b0;
        @(negedge clk);
        chk("mthi_hi", hi, 32'hABCD);
        chk("mthi_lo", lo, 32'd42);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        chk("arst_no_resume", dc, 0);
        issue(OP_MULTU, 32'd6, 32'd7);
        run(bc, dc);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_done", dc, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
